// File: rtl/mux_arbiter2.sv
// Two-requester round-robin arbiter driving a shared 2:1 data mux.
// A and B offer valid/ready streams. One side is granted at a time, and the
// granted beat is registered onto a single valid/ready output channel.
// A grant is capped at MAX_BURST beats whenever the other side is waiting.
module mux_arbiter2 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_q;       // side served by the latest grant: 0=A, 1=B
  logic [CNT_W-1:0] burst_cnt_q;  // beats accepted in the current burst window
  logic             sel_q;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;

  logic space;
  logic a_acc;
  logic b_acc;
  logic burst_end;

  // The output register can take a beat when empty or draining this cycle.
  assign space     = !out_valid_q || out_ready;
  assign a_ready   = (state_q == GRANT_A) && space;
  assign b_ready   = (state_q == GRANT_B) && space;
  assign a_acc     = a_valid && a_ready;
  assign b_acc     = b_valid && b_ready;
  assign burst_end = (burst_cnt_q == CNT_LAST);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

  // Output register next state: load an accepted beat, otherwise drain on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (a_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = a_data;
    end else if (b_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = b_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; data only changes on an accept, so it holds under back-pressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Arbitration FSM: grant selection, burst counting and forced hand-over.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;   // pretend B was last so A wins the first tie
      burst_cnt_q <= '0;
      sel_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_valid && b_valid) begin
            // Tie: the side not served last gets the grant.
            state_q     <= last_q ? GRANT_A : GRANT_B;
            last_q      <= !last_q;
            sel_q       <= !last_q;
            burst_cnt_q <= '0;
          end else if (a_valid) begin
            state_q     <= GRANT_A;
            last_q      <= 1'b0;
            sel_q       <= 1'b0;
            burst_cnt_q <= '0;
          end else if (b_valid) begin
            state_q     <= GRANT_B;
            last_q      <= 1'b1;
            sel_q       <= 1'b1;
            burst_cnt_q <= '0;
          end
        end

        GRANT_A: begin
          if (!a_valid) begin
            // Requester went away: hand straight over without an idle cycle.
            if (b_valid) begin
              state_q     <= GRANT_B;
              last_q      <= 1'b1;
              sel_q       <= 1'b1;
              burst_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (a_acc) begin
            if (burst_end) begin
              burst_cnt_q <= '0;
              if (b_valid) begin
                state_q <= GRANT_B;
                last_q  <= 1'b1;
                sel_q   <= 1'b1;
              end
            end else begin
              burst_cnt_q <= burst_cnt_q + CNT_ONE;
            end
          end
        end

        GRANT_B: begin
          if (!b_valid) begin
            if (a_valid) begin
              state_q     <= GRANT_A;
              last_q      <= 1'b0;
              sel_q       <= 1'b0;
              burst_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (b_acc) begin
            if (burst_end) begin
              burst_cnt_q <= '0;
              if (a_valid) begin
                state_q <= GRANT_A;
                last_q  <= 1'b0;
                sel_q   <= 1'b0;
              end
            end else begin
              burst_cnt_q <= burst_cnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter2.sv
// Bench for mux_arbiter2: directed scenarios plus a randomized run, all checked
// each cycle against a behavioural model of the arbitration rules.
module tb_mux_arbiter2;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Source queues, delivered-beat log and stimulus enables.
  logic [7:0] aq[$];
  logic [7:0] bq[$];
  logic [7:0] got[$];
  bit a_en = 1'b1;
  bit b_en = 1'b1;
  bit ordy = 1'b1;

  // Model state: owner -1=nobody, 0=A, 1=B; served = beats in current window.
  int         m_owner;
  int         m_last;
  int         m_served;
  bit         m_ov;
  bit         m_sel;
  logic [7:0] m_od;

  always #5 clock = ~clock;

  mux_arbiter2 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = 1;
    m_served = 0;
    m_ov     = 1'b0;
    m_sel    = 1'b0;
    m_od     = 8'h00;
  endfunction

  function automatic void grant(input int x);
    m_owner  = x;
    m_last   = x;
    m_sel    = (x == 1);
    m_served = 0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs now applied.
  function automatic void model_advance();
    bit         v[2];
    logic [7:0] d[2];
    bit         sp;
    bit         acc;
    int         me;
    int         other;
    if (!reset_n) begin
      model_reset();
      return;
    end
    v[0] = a_valid;
    v[1] = b_valid;
    d[0] = a_data;
    d[1] = b_data;
    sp   = !m_ov || out_ready;
    acc  = 1'b0;
    if (m_owner >= 0) acc = sp && v[m_owner];
    if (acc) begin
      m_ov = 1'b1;
      m_od = d[m_owner];
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      if (v[0] && v[1]) grant(1 - m_last);
      else if (v[0])    grant(0);
      else if (v[1])    grant(1);
    end else begin
      me    = m_owner;
      other = 1 - m_owner;
      if (!v[me]) begin
        if (v[other]) grant(other);
        else          m_owner = -1;
      end else if (acc) begin
        m_served++;
        if (m_served == MAX_BURST) begin
          if (v[other]) grant(other);
          else          m_served = 0;
        end
      end
    end
  endfunction

  // Apply inputs at the falling edge, check outputs, then advance one cycle.
  task automatic tick();
    bit sp;
    a_valid   = a_en && (aq.size() > 0);
    a_data    = (aq.size() > 0) ? aq[0] : 8'h00;
    b_valid   = b_en && (bq.size() > 0);
    b_data    = (bq.size() > 0) ? bq[0] : 8'h00;
    out_ready = ordy;
    #1;
    sp = !m_ov || out_ready;
    chk("a_ready",   a_ready,   (m_owner == 0) && sp);
    chk("b_ready",   b_ready,   (m_owner == 1) && sp);
    chk("out_valid", out_valid, m_ov);
    chk("out_data",  out_data,  m_od);
    chk("sel",       sel,       m_sel);
    chk("busy",      busy,      m_owner != -1);
    if (out_valid && out_ready) got.push_back(out_data);
    if (a_valid && a_ready) void'(aq.pop_front());
    if (b_valid && b_ready) void'(bq.pop_front());
    model_advance();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    aq.delete();
    bq.delete();
    got.delete();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_b;
    int         grp;
    reset_n   = 1'b0;
    a_valid   = 1'b0;
    a_data    = 8'h00;
    b_valid   = 1'b0;
    b_data    = 8'h00;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    tick();                      // reset state while reset held
    reset_n = 1'b1;

    // 1: asynchronous reset in the middle of an A burst, then first tie goes to A.
    for (int i = 0; i < 10; i++) aq.push_back(8'h31 + 8'(i));
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t1_rst_out_valid", out_valid, 1'b0);
    chk("t1_rst_out_data",  out_data,  8'h00);
    chk("t1_rst_sel",       sel,       1'b0);
    chk("t1_rst_a_ready",   a_ready,   1'b0);
    chk("t1_rst_b_ready",   b_ready,   1'b0);
    chk("t1_rst_busy",      busy,      1'b0);
    model_reset();
    aq.delete();
    bq.delete();
    got.delete();
    @(negedge clock);
    reset_n = 1'b1;
    aq = '{8'h41, 8'h42};
    bq = '{8'h51};
    repeat (8) tick();
    chk("t1_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_beat0", got[0], 8'h41);
      chk("t1_beat1", got[1], 8'h42);
      chk("t1_beat2", got[2], 8'h51);
    end

    // 2: A alone, 0x11..0x16; first beat two cycles after a_valid, then back-to-back.
    got.delete();
    for (int i = 0; i < 6; i++) aq.push_back(8'h11 + 8'(i));
    repeat (2) tick();
    chk("t2_before_first", got.size(), 0);
    tick();
    chk("t2_first_beat", got.size(), 1);
    repeat (5) tick();
    chk("t2_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("t2_beat", got[i], 8'h11 + 8'(i));
    repeat (3) tick();

    // 3: both sides streaming; groups of MAX_BURST alternate starting with A, no gaps.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      aq.push_back(8'hA0 + 8'(i));
      bq.push_back(8'hB0 + 8'(i));
    end
    repeat (18) tick();
    chk("t3_count", got.size(), 16);
    for (int k = 0; k < got.size(); k++) begin
      grp   = k / MAX_BURST;
      exp_b = ((grp % 2) == 0 ? 8'hA0 : 8'hB0) + 8'((grp / 2) * MAX_BURST + k % MAX_BURST);
      chk("t3_beat", got[k], exp_b);
    end
    repeat (3) tick();

    // 4: three cycles of downstream stall mid-burst; nothing lost or duplicated.
    got.delete();
    for (int i = 0; i < 8; i++) aq.push_back(8'h81 + 8'(i));
    repeat (3) tick();
    ordy = 1'b0;
    repeat (3) tick();
    ordy = 1'b1;
    repeat (10) tick();
    chk("t4_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("t4_beat", got[i], 8'h81 + 8'(i));

    // 5: A runs dry after 2 beats with B waiting -> direct hand-over, then idle.
    do_reset();
    aq = '{8'hC1, 8'hC2};
    bq = '{8'hD1, 8'hD2, 8'hD3};
    repeat (4) tick();
    chk("t5_sel_after_handover",  sel,  1'b1);
    chk("t5_busy_after_handover", busy, 1'b1);
    repeat (6) tick();
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_sel",  sel,  1'b1);
    chk("t5_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("t5_beat0", got[0], 8'hC1);
      chk("t5_beat1", got[1], 8'hC2);
      chk("t5_beat2", got[2], 8'hD1);
      chk("t5_beat4", got[4], 8'hD3);
    end

    // 6: tie after B was served goes to A; the following tie goes to B.
    got.delete();
    aq = '{8'h61};
    bq = '{8'h62};
    tick();
    b_en = 1'b0;
    repeat (5) tick();
    b_en = 1'b1;
    aq.push_back(8'h63);
    repeat (6) tick();
    chk("t6_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t6_beat0", got[0], 8'h61);
      chk("t6_beat1", got[1], 8'h62);
      chk("t6_beat2", got[2], 8'h63);
    end

    // Randomized traffic with random gating and back-pressure.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      a_en = ($urandom_range(0, 9) < 7);
      b_en = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 3) != 0);
      if (aq.size() < 3) aq.push_back(8'($urandom));
      if (bq.size() < 3) bq.push_back(8'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
